qmca_peak_detect: RTL and testbench

QMCA_PEAK_DETECT -- requirements
Module: qmca_peak_detect

---
 rtl/qmca_pkg.sv | 28 ++
 rtl/qmca_out_reg.sv | 72 +++++++
 rtl/qmca_peak_detect.sv | 219 +++++++++++++++++++++
 tb/tb_qmca_peak_detect.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/qmca_pkg.sv
// qmca_pkg
//   Shared definitions for the QMCA pulse-processing blocks: sample and
//   counter widths, the peak-detector FSM state encoding and a small
//   arithmetic helper used to apply the baseline correction.
package qmca_pkg;

  localparam int ADC_W  = 14;   // ADC sample width
  localparam int DROP_W = 16;   // dropped-result counter width
  localparam int CONF_W = 8;    // window / holdoff configuration width

  // Peak-detector FSM encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACQ     = 2'd1;
  localparam logic [1:0] ST_HOLDOFF = 2'd2;

  // Baseline-corrected height: a - b when a > b, otherwise zero.
  function automatic logic [ADC_W-1:0] sub_floor(input logic [ADC_W-1:0] a,
                                                 input logic [ADC_W-1:0] b);
    logic [ADC_W-1:0] r;
    if (a > b) begin
      r = a - b;
    end else begin
      r = {ADC_W{1'b0}};
    end
    return r;
  endfunction

endpackage

// File: rtl/qmca_out_reg.sv
// qmca_out_reg
//   Single-entry valid/ready output register. A new word loads when the
//   register is empty or is being emptied on the same edge (no bubble).
//   A word offered while the register is full and not being read is
//   discarded and reported with a one-cycle overflow pulse (registered).
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   in_valid      : a new word is offered this cycle
//   in_data       : the offered word
//   out_valid     : register holds a word
//   out_data      : the held word (stable until accepted)
//   out_ready     : consumer accepts the held word
//   overflow      : pulse, one offered word was discarded
module qmca_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         overflow
);

  logic         valid_r;
  logic [W-1:0] data_r;
  logic         overflow_r;
  logic         load_s;
  logic         drop_s;

  // Load / discard decision for the offered word
  always_comb begin
    load_s = 1'b0;
    drop_s = 1'b0;
    if (in_valid) begin
      if (!valid_r || out_ready) begin
        load_s = 1'b1;
      end else begin
        drop_s = 1'b1;
      end
    end else begin
      load_s = 1'b0;
      drop_s = 1'b0;
    end
  end

  // Storage register with handshake-driven valid flag
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r    <= 1'b0;
      data_r     <= {W{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= drop_s;
      if (load_s) begin
        valid_r <= 1'b1;
        data_r  <= in_data;
      end else if (valid_r && out_ready) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
    end
  end

  assign out_valid = valid_r;
  assign out_data  = data_r;
  assign overflow  = overflow_r;

endmodule

// File: rtl/qmca_peak_detect.sv
// qmca_peak_detect
//   Triggered peak search on an ADC sample stream. A trigger in IDLE opens
//   a window of conf_window samples (0 counts as 1) starting with the
//   trigger sample; the largest sample is tracked, the baseline removed and
//   the result (height, trigger timestamp, pile-up flag) handed to a
//   single-entry valid/ready output register. After each window the block
//   stays dead for conf_holdoff cycles. Acquisition never waits for the
//   consumer: results that find the output register full are counted.
// Ports
//   clk, rst       : clock, synchronous active-high reset
//   sel_adc_in     : ADC sample stream
//   trig           : one-cycle trigger aligned with the crossing sample
//   conf_window    : samples per search window
//   conf_holdoff   : dead cycles after each window
//   conf_baseline  : baseline subtracted from the peak
//   peak_height    : baseline-corrected height
//   peak_ts        : timestamp counter value at the trigger
//   peak_pileup    : another trigger arrived inside the window
//   peak_valid     : result available
//   peak_ready     : consumer accepts the result
//   busy           : FSM in ACQ or HOLDOFF
//   drop_cnt       : saturating count of discarded results
module qmca_peak_detect
  import qmca_pkg::*;
#(
  parameter int TS_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADC_W-1:0]  sel_adc_in,
  input  logic              trig,
  input  logic [CONF_W-1:0] conf_window,
  input  logic [CONF_W-1:0] conf_holdoff,
  input  logic [ADC_W-1:0]  conf_baseline,
  output logic [ADC_W-1:0]  peak_height,
  output logic [TS_W-1:0]   peak_ts,
  output logic              peak_pileup,
  output logic              peak_valid,
  input  logic              peak_ready,
  output logic              busy,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int RES_W = ADC_W + TS_W + 1;

  logic [1:0]        state_r,    state_nxt;
  logic [CONF_W-1:0] idx_r,      idx_nxt;
  logic [ADC_W-1:0]  max_r,      max_nxt;
  logic [TS_W-1:0]   ts_r,       ts_nxt;
  logic              pileup_r,   pileup_nxt;
  logic [CONF_W-1:0] win_r,      win_nxt;
  logic [CONF_W-1:0] hold_r,     hold_nxt;
  logic [ADC_W-1:0]  base_r,     base_nxt;
  logic [CONF_W-1:0] hold_cnt_r, hold_cnt_nxt;
  logic [TS_W-1:0]   ts_cnt_r;
  logic              busy_r;
  logic [DROP_W-1:0] drop_cnt_r;

  logic [CONF_W-1:0] win_eff_s;
  logic [ADC_W-1:0]  trk_max_s;
  logic              done_s;
  logic [ADC_W-1:0]  res_max_s;
  logic [ADC_W-1:0]  res_base_s;
  logic [TS_W-1:0]   res_ts_s;
  logic              res_pile_s;
  logic [CONF_W-1:0] res_hold_s;
  logic [ADC_W-1:0]  res_height_s;
  logic [RES_W-1:0]  res_data_s;
  logic [RES_W-1:0]  out_data_s;
  logic              overflow_s;

  // Free-running timestamp, wraps naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt_r <= {TS_W{1'b0}};
    end else begin
      ts_cnt_r <= ts_cnt_r + {{(TS_W-1){1'b0}}, 1'b1};
    end
  end

  // FSM and peak tracker next-state logic
  always_comb begin
    state_nxt    = state_r;
    idx_nxt      = idx_r;
    max_nxt      = max_r;
    ts_nxt       = ts_r;
    pileup_nxt   = pileup_r;
    win_nxt      = win_r;
    hold_nxt     = hold_r;
    base_nxt     = base_r;
    hold_cnt_nxt = hold_cnt_r;
    win_eff_s    = (conf_window == 8'd0) ? 8'd1 : conf_window;
    trk_max_s    = (sel_adc_in > max_r) ? sel_adc_in : max_r;
    done_s       = 1'b0;
    res_max_s    = max_r;
    res_base_s   = base_r;
    res_ts_s     = ts_r;
    res_pile_s   = pileup_r;
    res_hold_s   = hold_r;

    case (state_r)
      ST_IDLE: begin
        if (trig) begin
          max_nxt    = sel_adc_in;
          ts_nxt     = ts_cnt_r;
          pileup_nxt = 1'b0;
          win_nxt    = win_eff_s;
          hold_nxt   = conf_holdoff;
          base_nxt   = conf_baseline;
          idx_nxt    = 8'd1;
          if (win_eff_s == 8'd1) begin
            // One-sample window: the trigger sample is also the last one
            done_s       = 1'b1;
            res_max_s    = sel_adc_in;
            res_base_s   = conf_baseline;
            res_ts_s     = ts_cnt_r;
            res_pile_s   = 1'b0;
            res_hold_s   = conf_holdoff;
            hold_cnt_nxt = conf_holdoff;
            state_nxt    = (conf_holdoff != 8'd0) ? ST_HOLDOFF : ST_IDLE;
          end else begin
            state_nxt = ST_ACQ;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end

      ST_ACQ: begin
        max_nxt    = trk_max_s;
        pileup_nxt = pileup_r | trig;
        if (idx_r == (win_r - 8'd1)) begin
          // Last sample: a trigger here only marks pile-up
          done_s       = 1'b1;
          res_max_s    = trk_max_s;
          res_pile_s   = pileup_r | trig;
          hold_cnt_nxt = hold_r;
          state_nxt    = (hold_r != 8'd0) ? ST_HOLDOFF : ST_IDLE;
        end else begin
          idx_nxt = idx_r + 8'd1;
        end
      end

      ST_HOLDOFF: begin
        // hold_cnt counts remaining dead cycles including this one
        if (hold_cnt_r <= 8'd1) begin
          state_nxt = ST_IDLE;
        end else begin
          hold_cnt_nxt = hold_cnt_r - 8'd1;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM and tracker state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      idx_r      <= {CONF_W{1'b0}};
      max_r      <= {ADC_W{1'b0}};
      ts_r       <= {TS_W{1'b0}};
      pileup_r   <= 1'b0;
      win_r      <= {CONF_W{1'b0}};
      hold_r     <= {CONF_W{1'b0}};
      base_r     <= {ADC_W{1'b0}};
      hold_cnt_r <= {CONF_W{1'b0}};
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      idx_r      <= idx_nxt;
      max_r      <= max_nxt;
      ts_r       <= ts_nxt;
      pileup_r   <= pileup_nxt;
      win_r      <= win_nxt;
      hold_r     <= hold_nxt;
      base_r     <= base_nxt;
      hold_cnt_r <= hold_cnt_nxt;
      busy_r     <= (state_nxt != ST_IDLE);
    end
  end

  assign res_height_s = sub_floor(res_max_s, res_base_s);
  assign res_data_s   = {res_height_s, res_ts_s, res_pile_s};

  qmca_out_reg #(
    .W (RES_W)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (done_s),
    .in_data   (res_data_s),
    .out_valid (peak_valid),
    .out_data  (out_data_s),
    .out_ready (peak_ready),
    .overflow  (overflow_s)
  );

  // Saturating count of results the output register could not take
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_r <= {DROP_W{1'b0}};
    end else if (overflow_s && (drop_cnt_r != {DROP_W{1'b1}})) begin
      drop_cnt_r <= drop_cnt_r + {{(DROP_W-1){1'b0}}, 1'b1};
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign peak_height = out_data_s[RES_W-1 -: ADC_W];
  assign peak_ts     = out_data_s[TS_W:1];
  assign peak_pileup = out_data_s[0];
  assign busy        = busy_r;
  assign drop_cnt    = drop_cnt_r;

endmodule

// File: tb/tb_qmca_peak_detect.sv
// tb_qmca_peak_detect
//   Directed stimulus with hand-computed expectations pushed into a
//   scoreboard queue; a monitor pops and compares whenever a result is
//   presented, and checks arrival latency and stability while held.
module tb_qmca_peak_detect;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] sel_adc_in;
  logic        trig;
  logic [7:0]  conf_window;
  logic [7:0]  conf_holdoff;
  logic [13:0] conf_baseline;
  logic [13:0] peak_height;
  logic [31:0] peak_ts;
  logic        peak_pileup;
  logic        peak_valid;
  logic        peak_ready;
  logic        busy;
  logic [15:0] drop_cnt;

  typedef struct {
    logic [13:0] h;
    logic [31:0] ts;
    logic        pu;
    logic [31:0] rdy;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] tb_ts;
  logic [31:0] t0;

  qmca_peak_detect #(.TS_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .sel_adc_in    (sel_adc_in),
    .trig          (trig),
    .conf_window   (conf_window),
    .conf_holdoff  (conf_holdoff),
    .conf_baseline (conf_baseline),
    .peak_height   (peak_height),
    .peak_ts       (peak_ts),
    .peak_pileup   (peak_pileup),
    .peak_valid    (peak_valid),
    .peak_ready    (peak_ready),
    .busy          (busy),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference timestamp: cleared by reset, +1 per clock
  always @(posedge clk) begin
    if (rst) tb_ts <= 32'd0;
    else     tb_ts <= tb_ts + 32'd1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [13:0] h, input logic [31:0] ts, input logic pu, input logic [31:0] rdy);
    exp_t e;
    e.h = h; e.ts = ts; e.pu = pu; e.rdy = rdy;
    sb.push_back(e);
  endtask

  // Apply one cycle of stimulus and move to just after the next edge
  task automatic cyc(input logic t, input logic [13:0] s);
    trig       = t;
    sel_adc_in = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 14'd0);
  endtask

  task automatic monitor_loop();
    logic prev_valid;
    logic prev_hs;
    exp_t e;
    prev_valid = 1'b0;
    prev_hs    = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
        prev_hs    = 1'b0;
      end else if (peak_valid) begin
        chk("result_expected", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          e = sb[0];
          chk("height", 64'(peak_height), 64'(e.h));
          chk("ts", 64'(peak_ts), 64'(e.ts));
          chk("pileup", 64'(peak_pileup), 64'(e.pu));
          if (!prev_valid || prev_hs) chk("latency_cycle", 64'(tb_ts), 64'(e.rdy));
          if (peak_ready) void'(sb.pop_front());
        end
        prev_valid = 1'b1;
        prev_hs    = peak_ready;
      end else begin
        prev_valid = 1'b0;
        prev_hs    = 1'b0;
      end
    end
  endtask

  initial begin
    fork
      monitor_loop();
    join_none

    rst = 1'b1; trig = 1'b0; sel_adc_in = 14'd0; peak_ready = 1'b1;
    conf_window = 8'd4; conf_holdoff = 8'd0; conf_baseline = 14'd100;
    idle(2);
    chk("rst_valid", 64'(peak_valid), 64'd0);
    chk("rst_height", 64'(peak_height), 64'd0);
    chk("rst_ts", 64'(peak_ts), 64'd0);
    chk("rst_pileup", 64'(peak_pileup), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    rst = 1'b0;
    idle(3);

    // Basic window: max 350 - 100
    t0 = tb_ts;
    push(14'd250, t0, 1'b0, t0 + 32'd4);
    cyc(1'b1, 14'd200); cyc(1'b0, 14'd350); cyc(1'b0, 14'd300); cyc(1'b0, 14'd120);
    idle(4);

    // Baseline above peak -> 0
    conf_baseline = 14'd500;
    t0 = tb_ts;
    push(14'd0, t0, 1'b0, t0 + 32'd4);
    cyc(1'b1, 14'd300); cyc(1'b0, 14'd100); cyc(1'b0, 14'd50); cyc(1'b0, 14'd10);
    idle(4);

    // Pile-up: triggers at sample 3 and sample 7, one result
    conf_window = 8'd8; conf_baseline = 14'd0;
    t0 = tb_ts;
    push(14'd80, t0, 1'b1, t0 + 32'd8);
    for (int i = 0; i < 8; i++) cyc((i == 0) || (i == 3) || (i == 7), 14'(10 * (i + 1)));
    idle(6);

    // Holdoff 5, trigger every cycle: events every W+5 = 9 cycles
    conf_window = 8'd4; conf_holdoff = 8'd5;
    t0 = tb_ts;
    for (int k = 0; k < 3; k++) push(14'(1003 + 9 * k), t0 + 32'(9 * k), 1'b1, t0 + 32'(9 * k + 4));
    for (int i = 0; i < 22; i++) begin
      if (i == 6) chk("busy_holdoff", 64'(busy), 64'd1);
      cyc(1'b1, 14'(1000 + i));
    end
    idle(10);
    chk("busy_idle", 64'(busy), 64'd0);

    // Back-pressure: first held, next two dropped
    conf_window = 8'd2; conf_holdoff = 8'd0;
    peak_ready = 1'b0;
    t0 = tb_ts;
    push(14'd7, t0, 1'b0, t0 + 32'd2);
    cyc(1'b1, 14'd5); cyc(1'b0, 14'd7);
    cyc(1'b1, 14'd9); cyc(1'b0, 14'd4);
    cyc(1'b1, 14'd1); cyc(1'b0, 14'd2);
    idle(3);
    chk("drop_cnt_two", 64'(drop_cnt), 64'd2);
    // Accept on the same edge a new result completes: no bubble, no drop
    t0 = tb_ts;
    push(14'd11, t0, 1'b0, t0 + 32'd2);
    cyc(1'b1, 14'd11);
    peak_ready = 1'b1;
    cyc(1'b0, 14'd3);
    peak_ready = 1'b0;
    idle(3);
    chk("drop_cnt_same", 64'(drop_cnt), 64'd2);
    peak_ready = 1'b1;
    idle(3);

    // Reset in the middle of an acquisition
    conf_window = 8'd8;
    cyc(1'b1, 14'd900); cyc(1'b0, 14'd950); cyc(1'b0, 14'd999);
    rst = 1'b1;
    cyc(1'b0, 14'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_valid", 64'(peak_valid), 64'd0);
    chk("midrst_drop", 64'(drop_cnt), 64'd0);
    rst = 1'b0;
    idle(12);
    chk("midrst_busy_after", 64'(busy), 64'd0);

    // Window 0 behaves as 1
    conf_window = 8'd0; conf_baseline = 14'd50;
    t0 = tb_ts;
    push(14'd30, t0, 1'b0, t0 + 32'd1);
    cyc(1'b1, 14'd80);
    idle(5);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
